// File: rtl/next_queue_ctrl.sv
// rtl/next_queue_ctrl.sv - NEXT-piece queue fed by a 7-bag randomizer, valid/req spawn handshake
// Optional feature macro: SEED_LOAD_EN (runtime LFSR seed load). Piece codes 0..6 = I,O,T,J,L,S,Z; 7 = BLANK.
module next_queue_ctrl #(
    parameter int          NEXT_COUNT = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_l_i,
    input  logic                    game_restart_i,
    input  logic                    piece_req_i,
`ifdef SEED_LOAD_EN
    input  logic [15:0]             seed_i,
    input  logic                    seed_load_i,
`endif
    output logic                    piece_valid_o,
    output logic [2:0]              piece_type_o,
    output logic [3*NEXT_COUNT-1:0] pieces_queue_o
);
    localparam logic [2:0]    BLANK    = 3'd7;
    localparam logic [15:0]   SEED_RST = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam int            CW       = $clog2(NEXT_COUNT + 1);
    localparam logic [CW-1:0] FULL     = CW'(NEXT_COUNT);
    localparam logic [CW-1:0] LAST     = CW'(NEXT_COUNT - 1);

    typedef enum logic [1:0] {FILL, READY, REFILL} state_t;

    state_t                         state_q, state_d;
    logic [NEXT_COUNT-1:0][2:0]     queue_q, queue_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [6:0]                     used_q, used_d;
    logic                           valid_q, valid_d;
    logic [15:0]                    lfsr_q, lfsr_d;

    logic [2:0] start;
    logic [2:0] pick;
    logic [3:0] sum;
    logic [2:0] idx;
    logic [6:0] used_set;
    logic [6:0] used_pick;

    // Scan downwards so the last hit is the first free slot in circular order from start.
    always_comb begin
        start = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
        pick  = start;
        sum   = 4'd0;
        idx   = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            sum = {1'b0, start} + 4'(k);
            idx = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
            if (!used_q[idx]) begin
                pick = idx;
            end
        end
        used_set  = used_q | (7'b1 << pick);
        used_pick = (&used_set) ? 7'b0 : used_set;
    end

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`ifdef SEED_LOAD_EN
        if (seed_load_i) begin
            lfsr_d = (seed_i == 16'h0) ? 16'hACE1 : seed_i;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        queue_d = queue_q;
        count_d = count_q;
        used_d  = used_q;
        valid_d = valid_q;
        case (state_q)
            FILL: begin
                if (count_q < FULL) begin
                    queue_d[count_q] = pick;
                    count_d          = count_q + 1'b1;
                    used_d           = used_pick;
                    if (count_q == LAST) begin
                        state_d = READY;
                    end
                end else begin
                    state_d = READY;
                end
            end
            READY: begin
                if (piece_req_i && valid_q) begin
                    for (int i = 0; i < NEXT_COUNT - 1; i++) begin
                        queue_d[i] = queue_q[i+1];
                    end
                    queue_d[NEXT_COUNT-1] = BLANK;
                    count_d               = LAST;
                    valid_d               = 1'b0;
                    state_d               = REFILL;
                end else begin
                    valid_d = 1'b1;
                end
            end
            REFILL: begin
                queue_d[NEXT_COUNT-1] = pick;
                count_d               = FULL;
                used_d                = used_pick;
                valid_d               = 1'b1;
                state_d               = READY;
            end
            default: state_d = FILL;
        endcase
        // Restart wins over any pop or pick; the LFSR keeps running so games differ.
        if (game_restart_i) begin
            queue_d = {NEXT_COUNT{BLANK}};
            count_d = '0;
            used_d  = 7'b0;
            valid_d = 1'b0;
            state_d = FILL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_l_i) begin
        if (!rst_l_i) begin
            state_q <= FILL;
            queue_q <= {NEXT_COUNT{BLANK}};
            count_q <= '0;
            used_q  <= 7'b0;
            valid_q <= 1'b0;
            lfsr_q  <= SEED_RST;
        end else begin
            state_q <= state_d;
            queue_q <= queue_d;
            count_q <= count_d;
            used_q  <= used_d;
            valid_q <= valid_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign piece_valid_o  = valid_q;
    assign piece_type_o   = queue_q[0];
    assign pieces_queue_o = queue_q;

endmodule

// File: tb/tb_next_queue_ctrl.sv
// tb/tb_next_queue_ctrl.sv - randomized bench for next_queue_ctrl against a queue-based bag model
module tb_next_queue_ctrl;
    localparam int         N     = 5;
    localparam logic [2:0] BLANK = 3'd7;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          game_restart;
    logic          piece_req;
    logic          piece_valid;
    logic [2:0]    piece_type;
    logic [3*N-1:0] pieces_queue;
`ifdef SEED_LOAD_EN
    logic [15:0]   seed;
    logic          seed_load;
`endif

    int total  = 0;
    int passed = 0;

    logic [15:0] m_lfsr;
    bit   [6:0]  m_used;
    int          m_q[$];
    bit          m_valid;
    bit          m_refill;

    next_queue_ctrl #(.NEXT_COUNT(N), .LFSR_SEED(16'hACE1)) dut (
        .clk_i          (clk),
        .rst_l_i        (rst_l),
        .game_restart_i (game_restart),
        .piece_req_i    (piece_req),
`ifdef SEED_LOAD_EN
        .seed_i         (seed),
        .seed_load_i    (seed_load),
`endif
        .piece_valid_o  (piece_valid),
        .piece_type_o   (piece_type),
        .pieces_queue_o (pieces_queue)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_lfsr   = 16'hACE1;
        m_used   = '0;
        m_valid  = 1'b0;
        m_refill = 1'b0;
        m_q.delete();
    endfunction

    function automatic int model_pick();
        int c;
        c = int'(m_lfsr % 16'd8);
        if (c == 7) c = 0;
        for (int k = 0; k < 7; k++) begin
            int p;
            p = (c + k) % 7;
            if (!m_used[p]) begin
                m_used[p] = 1'b1;
                if (m_used == 7'h7f) m_used = '0;
                return p;
            end
        end
        return 7;
    endfunction

    function automatic void model_step(bit req, bit rs, bit sl, logic [15:0] sd);
        logic [15:0] nxt;
        nxt = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        if (sl) nxt = (sd == 16'h0) ? 16'hACE1 : sd;
        if (rs) begin
            m_q.delete();
            m_used   = '0;
            m_valid  = 1'b0;
            m_refill = 1'b0;
        end else if (m_valid && req) begin
            void'(m_q.pop_front());
            m_valid  = 1'b0;
            m_refill = 1'b1;
        end else if (m_q.size() < N) begin
            m_q.push_back(model_pick());
            if (m_refill) begin
                m_valid  = 1'b1;
                m_refill = 1'b0;
            end
        end else if (!m_valid) begin
            m_valid = 1'b1;
        end
        m_lfsr = nxt;
    endfunction

    function automatic logic [3*N-1:0] model_packed();
        logic [3*N-1:0] r;
        r = {N{BLANK}};
        for (int i = 0; i < m_q.size(); i++) r[3*i +: 3] = 3'(m_q[i]);
        return r;
    endfunction

    function automatic logic [2:0] model_head();
        return (m_q.size() == 0) ? BLANK : 3'(m_q[0]);
    endfunction

    task automatic tick();
        bit req, rs, sl;
        logic [15:0] sd;
        req = piece_req;
        rs  = game_restart;
        sl  = 1'b0;
        sd  = 16'h0;
`ifdef SEED_LOAD_EN
        sl = seed_load;
        sd = seed;
`endif
        @(posedge clk);
        model_step(req, rs, sl, sd);
        #1;
    endtask

    task automatic collect_pops(input int n, output logic [2:0] seq [14], output int got);
        int cyc;
        got = 0;
        cyc = 0;
        for (int i = 0; i < 14; i++) seq[i] = BLANK;
        piece_req = 1'b1;
        while (got < n && cyc < 80) begin
            if (piece_valid) begin
                seq[got] = piece_type;
                got++;
            end
            tick();
            cyc++;
        end
        piece_req = 1'b0;
    endtask

    task automatic test_reset();
        bit any_blank;
        rst_l = 1'b0; piece_req = 1'b0; game_restart = 1'b0;
`ifdef SEED_LOAD_EN
        seed = 16'h0; seed_load = 1'b0;
`endif
        repeat (3) begin @(posedge clk); #1; end
        total++; if (pieces_queue !== {N{BLANK}}) $display("FAIL reset_queue: got %h want %h", pieces_queue, {N{BLANK}}); else passed++;
        total++; if (piece_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", piece_valid); else passed++;
        total++; if (piece_type !== BLANK) $display("FAIL reset_type: got %0d want %0d", piece_type, BLANK); else passed++;
        rst_l = 1'b1;
        model_reset();
        for (int c = 1; c <= N + 1; c++) begin
            tick();
            total++; if (piece_valid !== (c == N + 1)) $display("FAIL fill_valid_c%0d: got %b want %b", c, piece_valid, (c == N + 1)); else passed++;
            total++; if (pieces_queue !== model_packed()) $display("FAIL fill_queue_c%0d: got %h want %h", c, pieces_queue, model_packed()); else passed++;
        end
        any_blank = 1'b0;
        for (int i = 0; i < N; i++) if (pieces_queue[3*i +: 3] == BLANK) any_blank = 1'b1;
        total++; if (any_blank !== 1'b0) $display("FAIL fill_no_blank: got queue %h", pieces_queue); else passed++;
        // Asynchronous reset mid-operation must clear outputs before any clock edge.
        repeat (4) tick();
        rst_l = 1'b0;
        #1;
        total++; if (pieces_queue !== {N{BLANK}}) $display("FAIL async_queue: got %h want %h", pieces_queue, {N{BLANK}}); else passed++;
        total++; if (piece_valid !== 1'b0) $display("FAIL async_valid: got %b want 0", piece_valid); else passed++;
        @(posedge clk); #1;
        rst_l = 1'b1;
        model_reset();
    endtask

    task automatic test_pop_held();
        int pops, cyc;
        logic pv;
        logic [7:0] mask1, mask2;
        game_restart = 1'b1; tick(); game_restart = 1'b0;
        piece_req = 1'b1;
        pops = 0; cyc = 0; mask1 = '0; mask2 = '0;
        while (pops < 14 && cyc < 60) begin
            pv = piece_valid;
            if (piece_valid) begin
                total++; if (piece_type !== model_head()) $display("FAIL held_head_p%0d: got %0d want %0d", pops, piece_type, model_head()); else passed++;
                if (pops < 7) mask1 = mask1 | (8'd1 << piece_type);
                else          mask2 = mask2 | (8'd1 << piece_type);
                pops++;
            end
            tick();
            cyc++;
            total++; if (pieces_queue !== model_packed()) $display("FAIL held_queue_c%0d: got %h want %h", cyc, pieces_queue, model_packed()); else passed++;
            if (pops > 0) begin
                total++; if (piece_valid !== ~pv) $display("FAIL held_toggle_c%0d: got %b want %b", cyc, piece_valid, ~pv); else passed++;
            end
        end
        piece_req = 1'b0;
        total++; if (pops !== 14) $display("FAIL held_pop_count: got %0d want 14", pops); else passed++;
        total++; if (mask1 !== 8'h7f) $display("FAIL held_bag1: got %h want 7f", mask1); else passed++;
        total++; if (mask2 !== 8'h7f) $display("FAIL held_bag2: got %h want 7f", mask2); else passed++;
    endtask

    task automatic test_single_pop();
        logic [2:0] exp_head;
        for (int w = 0; w < 10 && !piece_valid; w++) tick();
        total++; if (piece_valid !== 1'b1) $display("FAIL single_wait_valid: got %b want 1", piece_valid); else passed++;
        exp_head = 3'(m_q[1]);
        piece_req = 1'b1; tick(); piece_req = 1'b0;
        total++; if (piece_type !== exp_head) $display("FAIL single_head: got %0d want %0d", piece_type, exp_head); else passed++;
        total++; if (pieces_queue[3*(N-1) +: 3] !== BLANK) $display("FAIL single_last_blank: got %0d want %0d", pieces_queue[3*(N-1) +: 3], BLANK); else passed++;
        total++; if (piece_valid !== 1'b0) $display("FAIL single_valid_low: got %b want 0", piece_valid); else passed++;
        tick();
        total++; if (pieces_queue[3*(N-1) +: 3] === BLANK) $display("FAIL single_last_refilled: got %0d want non-blank", pieces_queue[3*(N-1) +: 3]); else passed++;
        total++; if (piece_valid !== 1'b1) $display("FAIL single_valid_high: got %b want 1", piece_valid); else passed++;
        total++; if (pieces_queue !== model_packed()) $display("FAIL single_queue: got %h want %h", pieces_queue, model_packed()); else passed++;
    endtask

    task automatic test_req_in_refill();
        int pre[$];
        bit shifted_ok;
        for (int w = 0; w < 10 && !piece_valid; w++) tick();
        total++; if (piece_valid !== 1'b1) $display("FAIL refill_wait_valid: got %b want 1", piece_valid); else passed++;
        pre = m_q;
        piece_req = 1'b1; tick();
        tick(); piece_req = 1'b0;
        shifted_ok = 1'b1;
        for (int i = 0; i < N - 1; i++) if (pieces_queue[3*i +: 3] !== 3'(pre[i+1])) shifted_ok = 1'b0;
        total++; if (shifted_ok !== 1'b1) $display("FAIL refill_no_extra_shift: got %h", pieces_queue); else passed++;
        total++; if (pieces_queue[3*(N-1) +: 3] === BLANK) $display("FAIL refill_last: got blank want piece"); else passed++;
        total++; if (piece_valid !== 1'b1) $display("FAIL refill_valid: got %b want 1", piece_valid); else passed++;
        total++; if (pieces_queue !== model_packed()) $display("FAIL refill_queue: got %h want %h", pieces_queue, model_packed()); else passed++;
    endtask

    task automatic test_restart();
        logic [2:0] seq [14];
        logic [7:0] mask;
        int got;
        for (int sc = 0; sc < 2; sc++) begin
            for (int w = 0; w < 10 && !piece_valid; w++) tick();
            total++; if (piece_valid !== 1'b1) $display("FAIL restart_wait_valid_s%0d: got %b want 1", sc, piece_valid); else passed++;
            piece_req = 1'b1;
            if (sc == 0) begin
                tick(); piece_req = 1'b0;
            end
            game_restart = 1'b1; tick(); game_restart = 1'b0; piece_req = 1'b0;
            total++; if (pieces_queue !== {N{BLANK}}) $display("FAIL restart_blank_s%0d: got %h want %h", sc, pieces_queue, {N{BLANK}}); else passed++;
            total++; if (piece_valid !== 1'b0) $display("FAIL restart_valid_s%0d: got %b want 0", sc, piece_valid); else passed++;
            total++; if (piece_type !== BLANK) $display("FAIL restart_type_s%0d: got %0d want %0d", sc, piece_type, BLANK); else passed++;
            collect_pops(7, seq, got);
            total++; if (got !== 7) $display("FAIL restart_pop_count_s%0d: got %0d want 7", sc, got); else passed++;
            mask = '0;
            for (int i = 0; i < 7; i++) mask = mask | (8'd1 << seq[i]);
            total++; if (mask !== 8'h7f) $display("FAIL restart_fresh_bag_s%0d: got %h want 7f", sc, mask); else passed++;
            total++; if (pieces_queue !== model_packed()) $display("FAIL restart_queue_s%0d: got %h want %h", sc, pieces_queue, model_packed()); else passed++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            piece_req    = ($urandom_range(0, 1) == 1);
            game_restart = ($urandom_range(0, 49) == 0);
            tick();
            total++; if (pieces_queue !== model_packed()) $display("FAIL rand_queue_c%0d: got %h want %h", c, pieces_queue, model_packed()); else passed++;
            total++; if (piece_valid !== m_valid) $display("FAIL rand_valid_c%0d: got %b want %b", c, piece_valid, m_valid); else passed++;
            total++; if (piece_type !== model_head()) $display("FAIL rand_type_c%0d: got %0d want %0d", c, piece_type, model_head()); else passed++;
        end
        piece_req = 1'b0; game_restart = 1'b0;
    endtask

`ifdef SEED_LOAD_EN
    task automatic seeded_run(input logic [15:0] s, output logic [2:0] seq [14], output int got);
        repeat (3) tick();
        seed = s; seed_load = 1'b1; game_restart = 1'b1;
        tick();
        seed_load = 1'b0; game_restart = 1'b0;
        collect_pops(14, seq, got);
    endtask

    task automatic test_seed_load();
        logic [2:0] a [14];
        logic [2:0] b [14];
        int ga, gb;
        bit same;
        seeded_run(16'h1234, a, ga);
        total++; if (pieces_queue !== model_packed()) $display("FAIL seed_model_queue: got %h want %h", pieces_queue, model_packed()); else passed++;
        seeded_run(16'h1234, b, gb);
        same = (ga == 14) && (gb == 14);
        for (int i = 0; i < 14; i++) if (a[i] !== b[i]) same = 1'b0;
        total++; if (same !== 1'b1) $display("FAIL seed_repeat: got differing sequences (%0d,%0d pops)", ga, gb); else passed++;
        seeded_run(16'h0000, a, ga);
        seeded_run(16'hACE1, b, gb);
        same = (ga == 14) && (gb == 14);
        for (int i = 0; i < 14; i++) if (a[i] !== b[i]) same = 1'b0;
        total++; if (same !== 1'b1) $display("FAIL seed_zero_is_ace1: got differing sequences (%0d,%0d pops)", ga, gb); else passed++;
        total++; if (pieces_queue !== model_packed()) $display("FAIL seed_model_queue2: got %h want %h", pieces_queue, model_packed()); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_pop_held();
        test_single_pop();
        test_req_in_refill();
        test_restart();
        test_random();
`ifdef SEED_LOAD_EN
        test_seed_load();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
